// File: rtl/timer_pkg.sv
// Shared timer definitions: converter FSM states, BCD digit width and a
// decimal power helper used for range thresholds.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/timer_bcd_converter_if.sv
// Valid/ready bundle between the timer, the BCD converter and the display path.
interface timer_bcd_converter_if #(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_value;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, bcd, overflow
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, bcd, overflow
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/timer_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with valid/ready on both sides and saturation to all nines on overflow.
module timer_bcd_converter
  import timer_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_bcd_converter_if.slave  bus
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic   [ACC_W-1:0]          r_acc;
  logic   [ACC_W-1:0]          w_acc_adj;
  logic   [IN_WIDTH-1:0]       r_sh;
  logic   [ACC_W+IN_WIDTH-1:0] w_cat;
  logic   [CNT_W-1:0]          r_cnt;
  logic   [ACC_W-1:0]          r_bcd;
  logic                        r_ovf;
  logic                        r_ovf_flag;
  logic                        w_in_ready;
  logic                        w_out_valid;
  logic                        w_accept;
  logic                        w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits and the remaining binary bits move left as one word.
  assign w_cat    = {w_acc_adj, r_sh} << 1;
  assign w_last   = (r_cnt == CNT_W'(IN_WIDTH - 1));
  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result register loads on the final shift so it is ready the cycle DONE begins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else if (w_accept) begin
      r_sh       <= bus.in_value;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= (64'(bus.in_value) >= pow10(DIGITS));
    end else if (r_state == SHIFT) begin
      r_acc <= w_cat[ACC_W+IN_WIDTH-1:IN_WIDTH];
      r_sh  <= w_cat[IN_WIDTH-1:0];
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_bcd <= r_ovf_flag ? ALL_NINES : w_cat[ACC_W+IN_WIDTH-1:IN_WIDTH];
        r_ovf <= r_ovf_flag;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.bcd       = r_bcd;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_timer_bcd_converter.sv
// Bench for timer_bcd_converter: a 4-digit and a 2-digit instance share stimulus
// and are checked against a decimal reference model.
module tb_timer_bcd_converter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  timer_bcd_converter_if #(.IN_WIDTH(10), .DIGITS(4)) if4 ();
  timer_bcd_converter_if #(.IN_WIDTH(10), .DIGITS(2)) if2 ();

  timer_bcd_converter #(.IN_WIDTH(10), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  timer_bcd_converter #(.IN_WIDTH(10), .DIGITS(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
    int unsigned lim;
    int unsigned x;
    logic [31:0] r;
    lim = 1;
    r   = '0;
    x   = v;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int unsigned v, input int digits);
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (v >= lim) ? 32'd1 : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] val, input logic ordy);
    if4.in_valid  = v;
    if4.in_value  = val;
    if4.out_ready = ordy;
    if2.in_valid  = v;
    if2.in_value  = val;
    if2.out_ready = ordy;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (if4.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned v);
    check({tag, "_bcd4"}, 32'(if4.bcd), ref_bcd(v, 4));
    check({tag, "_ovf4"}, 32'(if4.overflow), ref_ovf(v, 4));
    check({tag, "_vld2"}, 32'(if2.out_valid), 32'd1);
    check({tag, "_bcd2"}, 32'(if2.bcd), ref_bcd(v, 2));
    check({tag, "_ovf2"}, 32'(if2.overflow), ref_ovf(v, 2));
  endtask

  task automatic convert(input string tag, input int unsigned v);
    int lat;
    drive(1'b1, 10'(v), 1'b1);
    check({tag, "_rdy"}, 32'(if4.in_ready), 32'd1);
    tick();
    drive(1'b0, 10'($urandom), 1'b1);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'd10);
    check_result(tag, v);
    tick();
    check({tag, "_idle_vld"}, 32'(if4.out_valid), 32'd0);
    check({tag, "_idle_rdy"}, 32'(if4.in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    int unsigned q[$];
    int unsigned e;
    int          nxt;
    int          cyc;
    int          res;
    int          last_acc;
    logic        acc;

    drive(1'b0, 10'd0, 1'b1);
    tick();
    tick();
    check("rst_rdy", 32'(if4.in_ready), 32'd1);
    check("rst_vld", 32'(if4.out_valid), 32'd0);
    check("rst_bcd", 32'(if4.bcd), 32'd0);
    check("rst_ovf", 32'(if4.overflow), 32'd0);
    reset = 1'b1;
    tick();

    convert("zero", 0);
    convert("v999", 999);
    convert("v1023", 1023);
    convert("v150", 150);
    convert("v99", 99);
    convert("v100", 100);
    repeat (8) convert("rnd", $urandom_range(0, 1023));

    // Output held while the consumer stalls; busy-time requests are dropped.
    drive(1'b1, 10'd555, 1'b0);
    tick();
    drive(1'b0, 10'd0, 1'b0);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd10);
    check_result("bp", 555);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
      tick();
      check("bp_hold_bcd", 32'(if4.bcd), 32'h0555);
      check("bp_hold_vld", 32'(if4.out_valid), 32'd1);
      check("bp_hold_rdy", 32'(if4.in_ready), 32'd0);
    end
    drive(1'b0, 10'd0, 1'b1);
    tick();
    check("bp_rel_vld", 32'(if4.out_valid), 32'd0);
    check("bp_rel_rdy", 32'(if4.in_ready), 32'd1);
    repeat (12) tick();
    check("bp_noqueue", 32'(if4.out_valid), 32'd0);

    // Abort mid-conversion.
    drive(1'b1, 10'd777, 1'b1);
    tick();
    drive(1'b0, 10'd0, 1'b1);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_state_rdy", 32'(if4.in_ready), 32'd1);
    check("abort_vld", 32'(if4.out_valid), 32'd0);
    check("abort_bcd", 32'(if4.bcd), 32'd0);
    check("abort_bcd2", 32'(if2.bcd), 32'd0);
    check("abort_ovf", 32'(if4.overflow), 32'd0);
    convert("v42", 42);

    // Streaming 1..1000 with in_valid held high.
    q        = {};
    nxt      = 1;
    cyc      = 0;
    res      = 0;
    last_acc = -1;
    drive(1'b1, 10'd1, 1'b1);
    while (res < 1000 && cyc < 13000) begin
      acc = if4.in_valid && if4.in_ready;
      if (acc) q.push_back(nxt);
      if (if4.out_valid === 1'b1) begin
        e = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
        check("b2b_bcd4", 32'(if4.bcd), ref_bcd(e, 4));
        check("b2b_bcd2", 32'(if2.bcd), ref_bcd(e, 2));
        check("b2b_ovf2", 32'(if2.overflow), ref_ovf(e, 2));
        check("b2b_done_rdy", 32'(if4.in_ready), 32'd0);
        res++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) check("b2b_gap", 32'(cyc - last_acc), 32'd12);
        last_acc = cyc;
        nxt++;
        if (nxt <= 1000) drive(1'b1, 10'(nxt), 1'b1);
        else             drive(1'b0, 10'd0, 1'b1);
      end
    end
    check("b2b_count", 32'(res), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
